ipv4_arp_lut_arbiter: RTL

Shares the single IPv4 ARP LUT lookup port between NUM_REQ requesters, for example per-port forwarding pipelines. It arbitrates round-robin and issues one lookup at a time on the LUT next-hop (FIB) address interface. It pops the LUT result FIFO and returns the found flag and ethernet address to the granted requester with a valid/ready handshake. A watchdog returns not-found to the requester if the LUT never answers.

---
 rtl/ipv4_arp_lut_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ipv4_arp_lut_arbiter.sv
// Round-robin arbiter sharing one IPv4 ARP LUT lookup port between NUM_REQ requesters.
// Define IPV4_ARP_LUT_ARBITER_STATS_EN to add lookup/hit/timeout statistics counters.
module ipv4_arp_lut_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int REQ_BITS       = 2,
  parameter int MAC_WIDTH      = 48,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [32*NUM_REQ-1:0]  i_req_daddr,
  output logic [NUM_REQ-1:0]     o_req_ready,
  output logic [NUM_REQ-1:0]     o_rsp_valid,
  input  logic [NUM_REQ-1:0]     i_rsp_ready,
  output logic                   o_rsp_found,
  output logic [MAC_WIDTH-1:0]   o_rsp_eth_addr,
  output logic                   o_rsp_timeout,
  output logic                   o_lut_fib_daddr_valid,
  output logic [31:0]            o_lut_fib_daddr,
  input  logic                   i_lut_valid,
  input  logic                   i_lut_eth_addr_found,
  input  logic [MAC_WIDTH-1:0]   i_lut_eth_addr,
  output logic                   o_lut_rd,
  output logic                   o_busy
`ifdef IPV4_ARP_LUT_ARBITER_STATS_EN
  ,
  output logic [31:0]            o_stat_lookups,
  output logic [31:0]            o_stat_hits,
  output logic [31:0]            o_stat_timeouts
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t               state_q, state_d;
  logic [REQ_BITS-1:0]  ptr_q;
  logic [REQ_BITS-1:0]  gnt_q;
  logic [REQ_BITS-1:0]  gnt_idx;
  logic [REQ_BITS-1:0]  cand;
  logic                 gnt_any;
  logic [31:0]          daddr_q;
  logic                 found_q;
  logic                 timeout_q;
  logic [MAC_WIDTH-1:0] eth_q;
  logic [1:0]           drain_q;
  logic [7:0]           wdog_q;
  logic [7:0]           wdog_inc;
  logic                 rd_last_q;
  logic                 arb_en_q;
  logic                 arb_ok;
  logic                 rd_drain;
  logic                 rd_cap;
  logic                 wdog_hit;
  logic                 rsp_hs;
  logic                 rsp_st;

  // Lowest offset from the pointer wins, so iterate from the far end downwards.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = REQ_BITS'((int'(ptr_q) + i) % NUM_REQ);
      if (i_req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // arb_en_q holds off grants until the first edge after reset so o_req_ready is 0 in reset.
  assign arb_ok   = (state_q == S_IDLE) && arb_en_q && gnt_any && (drain_q != 2'd3);
  assign rd_drain = i_lut_valid && (drain_q != 2'd0) && !rd_last_q;
  assign rd_cap   = (state_q == S_WAIT) && i_lut_valid && (drain_q == 2'd0) && !rd_last_q;
  assign wdog_inc = wdog_q + 8'd1;
  assign wdog_hit = (state_q == S_WAIT) && !rd_cap && (wdog_inc == 8'(TIMEOUT_CYCLES));
  assign rsp_st   = (state_q == S_RESP);
  assign rsp_hs   = rsp_st && i_rsp_ready[gnt_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (arb_ok) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (rd_cap || wdog_hit) state_d = S_RESP;
      S_RESP:  if (rsp_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      daddr_q   <= '0;
      found_q   <= 1'b0;
      eth_q     <= '0;
      timeout_q <= 1'b0;
      drain_q   <= 2'd0;
      wdog_q    <= 8'd0;
      rd_last_q <= 1'b0;
      arb_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_last_q <= o_lut_rd;
      arb_en_q  <= 1'b1;
      if (arb_ok) begin
        gnt_q   <= gnt_idx;
        daddr_q <= i_req_daddr[32*gnt_idx +: 32];
        ptr_q   <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + REQ_BITS'(1);
      end
      if (state_q == S_ISSUE) wdog_q <= 8'd0;
      else if (state_q == S_WAIT) wdog_q <= wdog_inc;
      if (rd_cap) begin
        found_q   <= i_lut_eth_addr_found;
        eth_q     <= i_lut_eth_addr;
        timeout_q <= 1'b0;
      end else if (wdog_hit) begin
        found_q   <= 1'b0;
        eth_q     <= '0;
        timeout_q <= 1'b1;
      end
      // A late LUT answer is owed for every watchdog expiry; count saturates at 3.
      case ({wdog_hit, rd_drain})
        2'b10:   if (drain_q != 2'd3) drain_q <= drain_q + 2'd1;
        2'b01:   drain_q <= drain_q - 2'd1;
        default: drain_q <= drain_q;
      endcase
    end
  end

  assign o_req_ready           = arb_ok ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign o_lut_fib_daddr_valid = (state_q == S_ISSUE);
  assign o_lut_fib_daddr       = (state_q == S_ISSUE) ? daddr_q : 32'd0;
  assign o_lut_rd              = rd_drain || rd_cap;
  assign o_rsp_valid           = rsp_st ? (NUM_REQ'(1) << gnt_q) : '0;
  assign o_rsp_found           = rsp_st && found_q;
  assign o_rsp_eth_addr        = rsp_st ? eth_q : '0;
  assign o_rsp_timeout         = rsp_st && timeout_q;
  assign o_busy                = (state_q != S_IDLE);

`ifdef IPV4_ARP_LUT_ARBITER_STATS_EN
  logic [31:0] stat_lookups_q;
  logic [31:0] stat_hits_q;
  logic [31:0] stat_timeouts_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_lookups_q  <= 32'd0;
      stat_hits_q     <= 32'd0;
      stat_timeouts_q <= 32'd0;
    end else begin
      if (state_q == S_ISSUE) stat_lookups_q <= stat_lookups_q + 32'd1;
      if (rd_cap && i_lut_eth_addr_found) stat_hits_q <= stat_hits_q + 32'd1;
      if (wdog_hit) stat_timeouts_q <= stat_timeouts_q + 32'd1;
    end
  end

  assign o_stat_lookups  = stat_lookups_q;
  assign o_stat_hits     = stat_hits_q;
  assign o_stat_timeouts = stat_timeouts_q;
`endif

endmodule
